tile_xfer_sched: RTL and testbench

Ping-pong tile scheduler that sequences a DDR-to-DDR transfer of `task_len` words through two on-chip tile buffers. It splits the task into tiles of at most `TILE_LEN` words and issues load and store commands to the separate load and store engines. A load into one buffer overlaps the store out of the other buffer. It sits between the host-side task registers and the load/store Avalon engines, and replaces fixed-size tiling with a runtime-configured, double-buffered sequence.

---
 rtl/tile_xfer_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_tile_xfer_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_xfer_sched.sv
// -----------------------------------------------------------------------------
// tile_xfer_sched
//   Ping-pong tile scheduler for a DDR-to-DDR copy of task_len words through
//   two on-chip tile buffers. The task is cut into tiles of at most TILE_LEN
//   words. Tile k goes through buffer k mod 2, so the load into one buffer
//   overlaps the store out of the other buffer. At most one load and one store
//   are in flight at any time.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   task_start          : start pulse, sampled only while idle
//   task_raddr/_waddr   : source / destination byte addresses (word aligned)
//   task_len            : total words to move
//   task_busy           : high from the accepted start until task_done
//   task_done           : one-cycle completion pulse
//   load_start/_raddr/_len/_buf  : load command to the load engine
//   load_done           : load engine completion pulse
//   store_start/_waddr/_len/_buf : store command to the store engine
//   store_done          : store engine completion pulse
// -----------------------------------------------------------------------------
module tile_xfer_sched #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int LW       = 20,
  parameter int TILE_LEN = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          task_start,
  input  logic [DW-1:0] task_raddr,
  input  logic [DW-1:0] task_waddr,
  input  logic [LW-1:0] task_len,
  output logic          task_busy,
  output logic          task_done,
  output logic          load_start,
  output logic [DW-1:0] load_raddr,
  output logic [AW-1:0] load_len,
  output logic          load_buf,
  input  logic          load_done,
  output logic          store_start,
  output logic [DW-1:0] store_waddr,
  output logic [AW-1:0] store_len,
  output logic          store_buf,
  input  logic          store_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} top_state_t;
  typedef enum logic {LD_IDLE, LD_WAIT} ld_state_t;
  typedef enum logic {SD_IDLE, SD_WAIT} sd_state_t;

  top_state_t    r_state;
  ld_state_t     r_lstate;
  sd_state_t     r_sstate;

  logic          r_task_busy, r_task_done;
  logic          r_load_start, r_load_buf;
  logic [DW-1:0] r_load_raddr;
  logic [AW-1:0] r_load_len;
  logic          r_store_start, r_store_buf;
  logic [DW-1:0] r_store_waddr;
  logic [AW-1:0] r_store_len;

  logic [DW-1:0] r_rd_ptr, r_wr_ptr;   // next load / store addresses
  logic [LW-1:0] r_remaining;          // words not yet issued as loads
  logic [LW-1:0] r_tiles_total, r_tiles_stored;
  logic          r_next_load_buf, r_next_store_buf;
  logic [1:0]    r_full;
  logic [AW-1:0] r_len [2];

  // Engine completions only count while that side actually has a command out.
  logic          w_ld_ev, w_st_ev;
  logic          w_lbuf_nxt, w_sbuf_nxt, w_lidle_nxt, w_sidle_nxt;
  logic [1:0]    w_full_nxt;
  logic [AW-1:0] w_store_len, w_tile_len, w_first_tile;
  logic [LW:0]   w_len_round;
  logic [LW-1:0] w_tiles;
  logic          w_issue_load, w_issue_store, w_last_store;

  assign w_ld_ev     = load_done  && (r_lstate == LD_WAIT);
  assign w_st_ev     = store_done && (r_sstate == SD_WAIT);
  // While a command is outstanding the next_*_buf pointer still names its buffer.
  assign w_lbuf_nxt  = r_next_load_buf  ^ w_ld_ev;
  assign w_sbuf_nxt  = r_next_store_buf ^ w_st_ev;
  assign w_lidle_nxt = (r_lstate == LD_IDLE) || w_ld_ev;
  assign w_sidle_nxt = (r_sstate == SD_IDLE) || w_st_ev;

  // Buffer occupancy as it will be after this cycle's completions, so a
  // completion at cycle t can launch the follow-on command at t+1.
  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    w_full_nxt = r_full;
    if (w_st_ev) w_full_nxt[r_next_store_buf] = 1'b0;
    if (w_ld_ev) w_full_nxt[r_next_load_buf]  = 1'b1;
  end

  // A tile finishing its load this cycle has not reached r_len yet.
  assign w_store_len = (w_ld_ev && (r_next_load_buf == w_sbuf_nxt)) ? r_load_len
                                                                     : r_len[w_sbuf_nxt];

  assign w_tile_len   = (r_remaining > LW'(TILE_LEN)) ? AW'(TILE_LEN) : AW'(r_remaining);
  assign w_first_tile = (task_len    > LW'(TILE_LEN)) ? AW'(TILE_LEN) : AW'(task_len);
  assign w_len_round  = {1'b0, task_len} + (LW+1)'(TILE_LEN - 1);
  assign w_tiles      = LW'(w_len_round / (LW+1)'(TILE_LEN));

  assign w_issue_store = (r_state == ST_RUN) && w_sidle_nxt && w_full_nxt[w_sbuf_nxt];
  // The full flag stays set until store_done, so it also covers a store in flight.
  assign w_issue_load  = (r_state == ST_RUN) && (r_remaining != '0) && w_lidle_nxt &&
                         !w_full_nxt[w_lbuf_nxt] &&
                         !(!w_sidle_nxt && (r_next_store_buf == w_lbuf_nxt));
  assign w_last_store  = w_st_ev && ((r_tiles_stored + LW'(1)) == r_tiles_total);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_lstate         <= LD_IDLE;
      r_sstate         <= SD_IDLE;
      r_task_busy      <= 1'b0;
      r_task_done      <= 1'b0;
      r_load_start     <= 1'b0;
      r_load_raddr     <= '0;
      r_load_len       <= '0;
      r_load_buf       <= 1'b0;
      r_store_start    <= 1'b0;
      r_store_waddr    <= '0;
      r_store_len      <= '0;
      r_store_buf      <= 1'b0;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_remaining      <= '0;
      r_tiles_total    <= '0;
      r_tiles_stored   <= '0;
      r_next_load_buf  <= 1'b0;
      r_next_store_buf <= 1'b0;
      r_full           <= '0;
      // NOTE: the two-entry length store is plain flops, so it is cleared with
      // everything else; a real RAM array would be left unreset.
      r_len[0]         <= '0;
      r_len[1]         <= '0;
    end else begin
      r_load_start     <= 1'b0;
      r_store_start    <= 1'b0;
      r_task_done      <= 1'b0;
      r_full           <= w_full_nxt;
      r_next_load_buf  <= w_lbuf_nxt;
      r_next_store_buf <= w_sbuf_nxt;

      if (w_ld_ev) begin
        r_lstate                <= LD_IDLE;
        r_len[r_next_load_buf]  <= r_load_len;
      end
      if (w_st_ev) begin
        r_sstate       <= SD_IDLE;
        r_tiles_stored <= r_tiles_stored + LW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (task_start) begin
            r_state          <= ST_RUN;
            r_task_busy      <= 1'b1;
            r_tiles_total    <= w_tiles;
            r_tiles_stored   <= '0;
            r_full           <= '0;
            r_next_load_buf  <= 1'b0;
            r_next_store_buf <= 1'b0;
            r_wr_ptr         <= task_waddr;
            r_remaining      <= task_len - LW'(w_first_tile);
            r_rd_ptr         <= task_raddr + (DW'(w_first_tile) << 2);
            // Tile 0 is launched straight from the accept edge.
            if (task_len != '0) begin
              r_load_start <= 1'b1;
              r_load_raddr <= task_raddr;
              r_load_len   <= w_first_tile;
              r_load_buf   <= 1'b0;
              r_lstate     <= LD_WAIT;
            end
          end
        end

        ST_RUN: begin
          if (w_issue_load) begin
            r_load_start <= 1'b1;
            r_load_raddr <= r_rd_ptr;
            r_load_len   <= w_tile_len;
            r_load_buf   <= w_lbuf_nxt;
            r_rd_ptr     <= r_rd_ptr + (DW'(w_tile_len) << 2);
            r_remaining  <= r_remaining - LW'(w_tile_len);
            r_lstate     <= LD_WAIT;
          end
          if (w_issue_store) begin
            r_store_start <= 1'b1;
            r_store_waddr <= r_wr_ptr;
            r_store_len   <= w_store_len;
            r_store_buf   <= w_sbuf_nxt;
            r_wr_ptr      <= r_wr_ptr + (DW'(w_store_len) << 2);
            r_sstate      <= SD_WAIT;
          end
          if ((r_tiles_total == '0) || w_last_store) begin
            r_state     <= ST_FIN;
            r_task_done <= 1'b1;
            r_task_busy <= 1'b0;
          end
        end

        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign task_busy   = r_task_busy;
  assign task_done   = r_task_done;
  assign load_start  = r_load_start;
  assign load_raddr  = r_load_raddr;
  assign load_len    = r_load_len;
  assign load_buf    = r_load_buf;
  assign store_start = r_store_start;
  assign store_waddr = r_store_waddr;
  assign store_len   = r_store_len;
  assign store_buf   = r_store_buf;

endmodule

// File: tb/tb_tile_xfer_sched.sv
// -----------------------------------------------------------------------------
// tb_tile_xfer_sched
//   Directed bench for tile_xfer_sched. The bench plays the load and store
//   engines by hand, pulsing load_done / store_done at chosen cycles, and
//   compares command fields against hand-computed tile addresses and lengths.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_tile_xfer_sched;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 20;
  localparam int TL = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          task_start;
  logic [DW-1:0] task_raddr, task_waddr;
  logic [LW-1:0] task_len;
  logic          task_busy, task_done;
  logic          load_start, load_buf, load_done;
  logic [DW-1:0] load_raddr;
  logic [AW-1:0] load_len;
  logic          store_start, store_buf, store_done;
  logic [DW-1:0] store_waddr;
  logic [AW-1:0] store_len;

  tile_xfer_sched #(.AW(AW), .DW(DW), .LW(LW), .TILE_LEN(TL)) dut (
    .clk        (clk),
    .rst        (rst),
    .task_start (task_start),
    .task_raddr (task_raddr),
    .task_waddr (task_waddr),
    .task_len   (task_len),
    .task_busy  (task_busy),
    .task_done  (task_done),
    .load_start (load_start),
    .load_raddr (load_raddr),
    .load_len   (load_len),
    .load_buf   (load_buf),
    .load_done  (load_done),
    .store_start(store_start),
    .store_waddr(store_waddr),
    .store_len  (store_len),
    .store_buf  (store_buf),
    .store_done (store_done)
  );

  always #5 clk = ~clk;

  // {start, address, length, buffer} of each command port as one vector.
  logic [45:0] ld_cmd, st_cmd;
  assign ld_cmd = {load_start, load_raddr, load_len, load_buf};
  assign st_cmd = {store_start, store_waddr, store_len, store_buf};

  int n_vec = 0;
  int n_err = 0;
  int n_ld  = 0;
  int n_st  = 0;
  int n_dn  = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_start)  n_ld++;
    if (store_start) n_st++;
    if (task_done)   n_dn++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ld();
    load_done = 1'b1; step(); load_done = 1'b0;
  endtask

  task automatic pulse_st();
    store_done = 1'b1; step(); store_done = 1'b0;
  endtask

  task automatic pulse_both();
    load_done = 1'b1; store_done = 1'b1; step();
    load_done = 1'b0; store_done = 1'b0;
  endtask

  // Leaves the bench in cycle T+1 of a start pulse driven in cycle T.
  task automatic start_task(input logic [DW-1:0] ra, input logic [DW-1:0] wa,
                            input logic [LW-1:0] len);
    task_raddr = ra; task_waddr = wa; task_len = len; task_start = 1'b1;
    step();
    task_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; task_start = 1'b0; load_done = 1'b0; store_done = 1'b0;
    task_raddr = '0; task_waddr = '0; task_len = '0;
    step(); step();
    n_vec++;
    if ({task_busy, task_done, ld_cmd, st_cmd} !== '0) begin
      $display("FAIL reset_outputs got busy=%0b done=%0b ld=%h st=%h exp all 0",
               task_busy, task_done, ld_cmd, st_cmd);
      n_err++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_three_tile();
    int l0, s0, d0;
    l0 = n_ld; s0 = n_st; d0 = n_dn;
    start_task(32'h1000, 32'h8000, 20'd300);
    n_vec++;
    if ({task_busy, ld_cmd} !== {1'b1, 1'b1, 32'h1000, 12'd128, 1'b0}) begin
      $display("FAIL t3_load0 got busy=%0b ld=%h exp busy=1 ld=(1,1000,128,0)", task_busy, ld_cmd);
      n_err++;
    end
    step(); step();
    pulse_ld();
    n_vec++;
    if (st_cmd !== {1'b1, 32'h8000, 12'd128, 1'b0}) begin
      $display("FAIL t3_store0 got %h exp (1,8000,128,0)", st_cmd); n_err++;
    end
    n_vec++;
    if (ld_cmd !== {1'b1, 32'h1200, 12'd128, 1'b1}) begin
      $display("FAIL t3_load1 got %h exp (1,1200,128,1)", ld_cmd); n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if ({load_start, store_start} !== 2'b00) begin
      $display("FAIL t3_quiet got ld=%0b st=%0b exp 0 0", load_start, store_start); n_err++;
    end
    step(); pulse_ld();
    n_vec++;
    if ({st_cmd, ld_cmd} !== {1'b1, 32'h8200, 12'd128, 1'b1, 1'b1, 32'h1400, 12'd44, 1'b0}) begin
      $display("FAIL t3_tile1_2 got st=%h ld=%h exp st=(1,8200,128,1) ld=(1,1400,44,0)", st_cmd, ld_cmd);
      n_err++;
    end
    step(); pulse_st();
    step(); pulse_ld();
    n_vec++;
    if ({st_cmd, load_start} !== {1'b1, 32'h8400, 12'd44, 1'b0, 1'b0}) begin
      $display("FAIL t3_store2 got st=%h ld_start=%0b exp st=(1,8400,44,0) ld_start=0", st_cmd, load_start);
      n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if ({task_busy, task_done} !== 2'b01) begin
      $display("FAIL t3_done got busy=%0b done=%0b exp 0 1", task_busy, task_done); n_err++;
    end
    step(); step();
    n_vec++;
    if ({n_ld - l0, n_st - s0, n_dn - d0} !== {32'd3, 32'd3, 32'd1}) begin
      $display("FAIL t3_counts got loads=%0d stores=%0d done=%0d exp 3 3 1", n_ld - l0, n_st - s0, n_dn - d0);
      n_err++;
    end
  endtask

  task automatic test_back_pressure();
    logic seen = 1'b0;
    start_task(32'h1000, 32'h8000, 20'd300);
    step(); pulse_ld();   // store0 on buf 0, load1 on buf 1
    step(); pulse_ld();   // load1 done: store side busy, buf 0 still full
    n_vec++;
    if ({load_start, store_start} !== 2'b00) begin
      $display("FAIL bp_stall got ld=%0b st=%0b exp 0 0", load_start, store_start); n_err++;
    end
    repeat (46) begin
      step();
      if (load_start || store_start) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      $display("FAIL bp_no_early_cmd got 1 exp 0"); n_err++;
    end
    pulse_st();           // tile 0 store done frees buf 0
    n_vec++;
    if ({ld_cmd, st_cmd} !== {1'b1, 32'h1400, 12'd44, 1'b0, 1'b1, 32'h8200, 12'd128, 1'b1}) begin
      $display("FAIL bp_release got ld=%h st=%h exp ld=(1,1400,44,0) st=(1,8200,128,1)", ld_cmd, st_cmd);
      n_err++;
    end
    step(); pulse_ld();
    n_vec++;
    if (store_start !== 1'b0) begin
      $display("FAIL bp_store_busy got %0b exp 0", store_start); n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if (st_cmd !== {1'b1, 32'h8400, 12'd44, 1'b0}) begin
      $display("FAIL bp_store2 got %h exp (1,8400,44,0)", st_cmd); n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if (task_done !== 1'b1) begin
      $display("FAIL bp_done got %0b exp 1", task_done); n_err++;
    end
    step();
  endtask

  task automatic test_boundary_len();
    int l0, s0;
    l0 = n_ld; s0 = n_st;
    start_task(32'h0, 32'h0, 20'd0);
    n_vec++;
    if ({task_busy, load_start} !== 2'b10) begin
      $display("FAIL len0_T1 got busy=%0b ld=%0b exp 1 0", task_busy, load_start); n_err++;
    end
    step();
    n_vec++;
    if ({task_busy, task_done, load_start, store_start} !== 4'b0100) begin
      $display("FAIL len0_T2 got busy=%0b done=%0b ld=%0b st=%0b exp 0 1 0 0",
               task_busy, task_done, load_start, store_start);
      n_err++;
    end
    step(); step();
    n_vec++;
    if ({n_ld - l0, n_st - s0} !== {32'd0, 32'd0}) begin
      $display("FAIL len0_cmds got loads=%0d stores=%0d exp 0 0", n_ld - l0, n_st - s0); n_err++;
    end

    l0 = n_ld; s0 = n_st;
    start_task(32'h4000, 32'h5000, 20'd128);
    n_vec++;
    if (ld_cmd !== {1'b1, 32'h4000, 12'd128, 1'b0}) begin
      $display("FAIL len128_load got %h exp (1,4000,128,0)", ld_cmd); n_err++;
    end
    step(); pulse_ld();
    n_vec++;
    if ({st_cmd, load_start} !== {1'b1, 32'h5000, 12'd128, 1'b0, 1'b0}) begin
      $display("FAIL len128_store got st=%h ld_start=%0b exp (1,5000,128,0) 0", st_cmd, load_start);
      n_err++;
    end
    step(); pulse_st();   // now in u+1
    n_vec++;
    if ({task_busy, task_done} !== 2'b01) begin
      $display("FAIL len128_done got busy=%0b done=%0b exp 0 1", task_busy, task_done); n_err++;
    end
    // Start held from u+1: ignored in the done cycle, accepted at u+2.
    task_len = 20'd0; task_start = 1'b1;
    step();
    n_vec++;
    if (task_busy !== 1'b0) begin
      $display("FAIL restart_u1 got busy=%0b exp 0", task_busy); n_err++;
    end
    step(); task_start = 1'b0;
    n_vec++;
    if (task_busy !== 1'b1) begin
      $display("FAIL restart_u2 got busy=%0b exp 1", task_busy); n_err++;
    end
    step(); step(); step();
    n_vec++;
    if ({n_ld - l0, n_st - s0} !== {32'd1, 32'd1}) begin
      $display("FAIL len128_cmds got loads=%0d stores=%0d exp 1 1", n_ld - l0, n_st - s0); n_err++;
    end
  endtask

  task automatic test_simultaneous();
    start_task(32'h1000, 32'h8000, 20'd300);
    step(); pulse_ld();
    step(); pulse_both(); // load1 done (buf 1) and store0 done (buf 0) together
    n_vec++;
    if ({st_cmd, ld_cmd} !== {1'b1, 32'h8200, 12'd128, 1'b1, 1'b1, 32'h1400, 12'd44, 1'b0}) begin
      $display("FAIL sim_both got st=%h ld=%h exp st=(1,8200,128,1) ld=(1,1400,44,0)", st_cmd, ld_cmd);
      n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if (store_start !== 1'b0) begin
      $display("FAIL sim_wait_load2 got %0b exp 0", store_start); n_err++;
    end
    step(); pulse_ld();
    n_vec++;
    if (st_cmd !== {1'b1, 32'h8400, 12'd44, 1'b0}) begin
      $display("FAIL sim_store2 got %h exp (1,8400,44,0)", st_cmd); n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if (task_done !== 1'b1) begin
      $display("FAIL sim_done got %0b exp 1", task_done); n_err++;
    end
    step();
  endtask

  task automatic test_spurious();
    int l0, s0, d0;
    l0 = n_ld; s0 = n_st; d0 = n_dn;
    pulse_ld(); pulse_st(); step(); step();
    n_vec++;
    if ({task_busy, n_ld - l0, n_st - s0, n_dn - d0} !== {1'b0, 32'd0, 32'd0, 32'd0}) begin
      $display("FAIL idle_spurious got busy=%0b loads=%0d stores=%0d done=%0d exp 0 0 0 0",
               task_busy, n_ld - l0, n_st - s0, n_dn - d0);
      n_err++;
    end
    l0 = n_ld;
    start_task(32'h6000, 32'h7000, 20'd128);
    step();
    task_raddr = 32'hdead0; task_len = 20'd5; task_start = 1'b1;
    step(); task_start = 1'b0;
    n_vec++;
    if ({task_busy, load_start} !== 2'b10) begin
      $display("FAIL busy_start got busy=%0b ld=%0b exp 1 0", task_busy, load_start); n_err++;
    end
    pulse_ld();
    n_vec++;
    if (st_cmd !== {1'b1, 32'h7000, 12'd128, 1'b0}) begin
      $display("FAIL busy_store got %h exp (1,7000,128,0)", st_cmd); n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if (task_done !== 1'b1) begin
      $display("FAIL busy_done got %0b exp 1", task_done); n_err++;
    end
    step(); step();
    n_vec++;
    if (n_ld - l0 !== 1) begin
      $display("FAIL busy_loads got %0d exp 1", n_ld - l0); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_task(32'h1000, 32'h8000, 20'd300);
    step(); pulse_ld();
    n_vec++;
    if (ld_cmd !== {1'b1, 32'h1200, 12'd128, 1'b1}) begin
      $display("FAIL rm_load1 got %h exp (1,1200,128,1)", ld_cmd); n_err++;
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({task_busy, task_done, ld_cmd, st_cmd} !== '0) begin
      $display("FAIL rm_outputs got busy=%0b done=%0b ld=%h st=%h exp all 0",
               task_busy, task_done, ld_cmd, st_cmd);
      n_err++;
    end
    d0 = n_dn;
    step(); rst = 1'b0;
    step(); step(); step();
    n_vec++;
    if ({task_busy, n_dn - d0} !== {1'b0, 32'd0}) begin
      $display("FAIL rm_no_done got busy=%0b done_pulses=%0d exp 0 0", task_busy, n_dn - d0); n_err++;
    end
    start_task(32'h2000, 32'h3000, 20'd10);
    n_vec++;
    if (ld_cmd !== {1'b1, 32'h2000, 12'd10, 1'b0}) begin
      $display("FAIL rm_new_load got %h exp (1,2000,10,0)", ld_cmd); n_err++;
    end
    step(); pulse_ld();
    n_vec++;
    if (st_cmd !== {1'b1, 32'h3000, 12'd10, 1'b0}) begin
      $display("FAIL rm_new_store got %h exp (1,3000,10,0)", st_cmd); n_err++;
    end
    step(); pulse_st();
    n_vec++;
    if ({task_busy, task_done} !== 2'b01) begin
      $display("FAIL rm_new_done got busy=%0b done=%0b exp 0 1", task_busy, task_done); n_err++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_three_tile();
    test_back_pressure();
    test_boundary_len();
    test_simultaneous();
    test_spurious();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
